// File: rtl/dynamic_branch_predictor.sv
// Table of 2-bit saturating counters for conditional branches. Untrained entries fall back to backward-taken.
// Optional gshare indexing via DYN_BP_GSHARE_EN; prediction is combinational, training is registered at resolve.
module dynamic_branch_predictor #(
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_BITS  = 6,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   Branch_d,
   input  logic [DATA_WIDTH-1:0]  PC_d,
   input  logic [DATA_WIDTH-1:0]  ImmExt_d,
   output logic                   predict_taken,
   output logic [DATA_WIDTH-1:0]  predict_target,
   output logic [INDEX_BITS-1:0]  pred_index_d,
   input  logic                   Branch_e,
   input  logic [INDEX_BITS-1:0]  upd_index_e,
   input  logic                   taken_e,
   input  logic                   predicted_e,
   output logic                   mispredict_e,
   output logic [COUNT_WIDTH-1:0] branch_count,
   output logic [COUNT_WIDTH-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            ctr [ENTRIES];
   logic [ENTRIES-1:0]    valid;
   logic [INDEX_BITS-1:0] pc_index;
   logic                  static_taken;

   assign pc_index       = PC_d[INDEX_BITS+1:2];
   assign predict_target = PC_d + ImmExt_d;
   assign static_taken   = (predict_target < PC_d);

`ifdef DYN_BP_GSHARE_EN
   logic [INDEX_BITS-1:0] ghr;

   assign pred_index_d = pc_index ^ ghr;

   // History advances only on resolved branches, so it never needs repair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (Branch_e)
         ghr <= {ghr[INDEX_BITS-2:0], taken_e};
   end
`else
   assign pred_index_d = pc_index;
`endif

   always_comb begin
      predict_taken = 1'b0;
      if (rst_n && Branch_d)
         predict_taken = valid[pred_index_d] ? ctr[pred_index_d][1] : static_taken;
   end

   assign mispredict_e = rst_n & Branch_e & (predicted_e != taken_e);

   // Untrained entries sit at 01, so the first update lands on 10 or 00 naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++)
            ctr[i] <= 2'b01;
      end else if (Branch_e) begin
         valid[upd_index_e] <= 1'b1;
         if (taken_e) begin
            if (ctr[upd_index_e] != 2'b11)
               ctr[upd_index_e] <= ctr[upd_index_e] + 2'd1;
         end else begin
            if (ctr[upd_index_e] != 2'b00)
               ctr[upd_index_e] <= ctr[upd_index_e] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (Branch_e) begin
         if (branch_count != '1)
            branch_count <= branch_count + COUNT_ONE;
         if (mispredict_e && (mispredict_count != '1))
            mispredict_count <= mispredict_count + COUNT_ONE;
      end
   end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed bench for dynamic_branch_predictor with 4-bit performance counters.
module tb_dynamic_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Branch_d = 1'b0;
   logic [31:0] PC_d = '0;
   logic [31:0] ImmExt_d = '0;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic [5:0]  pred_index_d;
   logic        Branch_e = 1'b0;
   logic [5:0]  upd_index_e = '0;
   logic        taken_e = 1'b0;
   logic        predicted_e = 1'b0;
   logic        mispredict_e;
   logic [3:0]  branch_count;
   logic [3:0]  mispredict_count;

   int nchk = 0;
   int npass = 0;
   int exp_br = 0;
   int exp_mp = 0;

   localparam logic [31:0] BACK = 32'hFFFF_FFF0;
   localparam logic [31:0] FWD  = 32'h0000_0010;

   dynamic_branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6), .COUNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .Branch_d(Branch_d), .PC_d(PC_d), .ImmExt_d(ImmExt_d),
      .predict_taken(predict_taken), .predict_target(predict_target), .pred_index_d(pred_index_d),
      .Branch_e(Branch_e), .upd_index_e(upd_index_e), .taken_e(taken_e), .predicted_e(predicted_e),
      .mispredict_e(mispredict_e), .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         npass++;
   endtask

   task automatic decode(input logic [31:0] pc, input logic [31:0] imm);
      Branch_d = 1'b1;
      PC_d = pc;
      ImmExt_d = imm;
      #1;
   endtask

   task automatic resolve(input logic [5:0] idx, input logic tk, input logic pr);
      Branch_e = 1'b1;
      upd_index_e = idx;
      taken_e = tk;
      predicted_e = pr;
      #1;
      chk("mispredict_e", {31'd0, mispredict_e}, {31'd0, tk != pr});
      tick();
      Branch_e = 1'b0;
      if (exp_br < 15) exp_br++;
      if (tk != pr && exp_mp < 15) exp_mp++;
   endtask

   task automatic test_reset();
      decode(32'h100, BACK);
      chk("reset_predict", {31'd0, predict_taken}, 32'd0);
      chk("reset_branch_count", {28'd0, branch_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      decode(32'h100, BACK);
      chk("static_backward", {31'd0, predict_taken}, 32'd1);
      chk("target_backward", predict_target, 32'h0000_00F0);
      decode(32'h100, FWD);
      chk("static_forward", {31'd0, predict_taken}, 32'd0);
      chk("branch_count_0", {28'd0, branch_count}, 32'd0);
      chk("mispredict_count_0", {28'd0, mispredict_count}, 32'd0);
      Branch_d = 1'b0;
      decode(32'h100, BACK);
      Branch_d = 1'b0;
      #1;
      chk("no_branch_d", {31'd0, predict_taken}, 32'd0);
   endtask

   task automatic test_loop();
      // PC 0x100 maps to index 0; forward offset shows the table overriding static.
      resolve(6'd0, 1'b1, 1'b1);
      decode(32'h100, FWD);
      chk("loop_after_T1", {31'd0, predict_taken}, 32'd1);
      resolve(6'd0, 1'b1, 1'b1);
      resolve(6'd0, 1'b0, 1'b1);
      decode(32'h100, FWD);
      chk("loop_after_NT1", {31'd0, predict_taken}, 32'd1);
      resolve(6'd0, 1'b0, 1'b1);
      decode(32'h100, BACK);
      chk("loop_after_NT2", {31'd0, predict_taken}, 32'd0);
      chk("loop_branch_count", {28'd0, branch_count}, exp_br);
      chk("loop_mispredict_count", {28'd0, mispredict_count}, exp_mp);
   endtask

   task automatic test_forward();
      decode(32'h40, 32'h20);
      chk("fwd_untrained", {31'd0, predict_taken}, 32'd0);
      chk("fwd_index", {26'd0, pred_index_d}, 32'd16);
      resolve(6'd16, 1'b1, 1'b0);
      decode(32'h40, 32'h20);
      chk("fwd_trained", {31'd0, predict_taken}, 32'd1);
   endtask

   task automatic test_same_cycle();
      decode(32'h14, FWD);
      Branch_e = 1'b1;
      upd_index_e = 6'd5;
      taken_e = 1'b1;
      predicted_e = 1'b0;
      #1;
      chk("same_cycle_pre", {31'd0, predict_taken}, 32'd0);
      tick();
      Branch_e = 1'b0;
      if (exp_br < 15) exp_br++;
      if (exp_mp < 15) exp_mp++;
      #1;
      chk("same_cycle_post", {31'd0, predict_taken}, 32'd1);
   endtask

   task automatic test_ctr_saturation();
      for (int i = 0; i < 10; i++)
         resolve(6'd7, 1'b1, 1'b1);
      resolve(6'd7, 1'b0, 1'b1);
      decode(32'h1C, BACK);
      chk("ctr_sat_one_nt", {31'd0, predict_taken}, 32'd1);
      resolve(6'd7, 1'b0, 1'b1);
      decode(32'h1C, BACK);
      chk("ctr_sat_two_nt", {31'd0, predict_taken}, 32'd0);
   endtask

   task automatic test_perf_saturation();
      for (int i = 0; i < 20; i++)
         resolve(6'd9, 1'b0, 1'b1);
      chk("branch_count_sat", {28'd0, branch_count}, 32'd15);
      chk("mispredict_count_sat", {28'd0, mispredict_count}, 32'd15);
      chk("branch_count_model", {28'd0, branch_count}, exp_br);
   endtask

   task automatic test_async_reset();
      decode(32'h40, 32'h20);
      chk("pre_reset_trained", {31'd0, predict_taken}, 32'd1);
      Branch_e = 1'b1;
      upd_index_e = 6'd16;
      taken_e = 1'b1;
      predicted_e = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_predict", {31'd0, predict_taken}, 32'd0);
      chk("async_mispredict_e", {31'd0, mispredict_e}, 32'd0);
      chk("async_branch_count", {28'd0, branch_count}, 32'd0);
      chk("async_mispredict_count", {28'd0, mispredict_count}, 32'd0);
      tick();
      Branch_e = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post_reset_untrained", {31'd0, predict_taken}, 32'd0);
      chk("post_reset_count", {28'd0, branch_count}, 32'd0);
      exp_br = 0;
      exp_mp = 0;
   endtask

   task automatic test_index();
      resolve(6'd3, 1'b1, 1'b1);
      resolve(6'd3, 1'b1, 1'b1);
      resolve(6'd3, 1'b0, 1'b1);
      decode(32'h104, FWD);
`ifdef DYN_BP_GSHARE_EN
      chk("gshare_index", {26'd0, pred_index_d}, 32'd7);
`else
      chk("pc_index", {26'd0, pred_index_d}, 32'd1);
`endif
      chk("index_branch_count", {28'd0, branch_count}, exp_br);
   endtask

   initial begin
      test_reset();
      test_loop();
      test_forward();
      test_same_cycle();
      test_ctr_saturation();
      test_perf_saturation();
      test_async_reset();
      test_index();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
